pq_sched: RTL and testbench



---
 rtl/pq_pkg.sv | 23 ++
 rtl/pq_rr_arb.sv | 21 ++
 rtl/pq_sched.sv | 172 +++++++++++++++++
 tb/tb_pq_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the quickq request scheduler: key/value entry, operation code and FSM states.
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 16;
  localparam int KV_W  = KEY_W + VAL_W;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic {
    PQ_PUSH = 1'b0,
    PQ_POP  = 1'b1
  } pq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } pq_sched_state_t;
endpackage

// File: rtl/pq_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or after ptr,
// wrapping from NREQ-1 back to 0.
module pq_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   rot_gnt;
  logic [2*NREQ-1:0] gdbl;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot     = NREQ'({req, req} >> ptr);
    rot_gnt = rot & (~rot + NREQ'(1));
    gdbl    = {{NREQ{1'b0}}, rot_gnt} << ptr;
    grant   = gdbl[2*NREQ-1:NREQ] | gdbl[NREQ-1:0];
  end
endmodule

// File: rtl/pq_sched.sv
// Round-robin push/pop scheduler in front of a single quickq priority queue:
// one operation in flight, watchdog on the busy phase, occupancy tracking.
module pq_sched
  import pq_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int TMO   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_op,
  input  logic [NREQ*KV_W-1:0]       req_kv,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [KV_W-1:0]            rsp_kv,
  output logic                       rsp_err,
  output logic                       pq_enq,
  output logic                       pq_deq,
  output logic [KV_W-1:0]            pq_kvi,
  input  logic [KV_W-1:0]            pq_kvo,
  input  logic                       pq_full,
  input  logic                       pq_empty,
  input  logic                       pq_busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TMO+1);

  pq_sched_state_t state_q, state_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  pq_op_t          op_q, op_d;
  kv_t             kv_q, kv_d;
  kv_t             hd_q, hd_d;
  kv_t             rsp_kv_q, rsp_kv_d;
  logic            err_q, err_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   count_q, count_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   g_id;
  pq_op_t          g_op;
  kv_t             g_kv;

  pq_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    g_id = '0;
    g_op = PQ_PUSH;
    g_kv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_id = IW'(i);
        g_op = pq_op_t'(req_op[i]);
        g_kv = req_kv[i*KV_W +: KV_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      ptr_q    <= '0;
      op_q     <= PQ_PUSH;
      kv_q     <= '0;
      hd_q     <= '0;
      rsp_kv_q <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      kv_q     <= kv_d;
      hd_q     <= hd_d;
      rsp_kv_q <= rsp_kv_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    kv_d      = kv_q;
    hd_d      = hd_q;
    rsp_kv_d  = rsp_kv_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    count_d   = count_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    pq_enq    = 1'b0;
    pq_deq    = 1'b0;
    pq_kvi    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so a held request shows no grant while reset is asserted.
        req_ready = rst_n ? grant : '0;
        if (|grant) begin
          id_d    = g_id;
          op_d    = g_op;
          kv_d    = g_kv;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wcnt_d = '0;
        if ((op_q == PQ_PUSH && pq_full) || (op_q == PQ_POP && pq_empty)) begin
          err_d    = 1'b1;
          rsp_kv_d = '0;
          state_d  = ST_RESP;
        end else if (op_q == PQ_PUSH) begin
          pq_enq  = 1'b1;
          pq_kvi  = kv_q;
          state_d = ST_WAIT;
        end else begin
          pq_deq  = 1'b1;
          hd_d    = pq_kvo;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!pq_busy) begin
          rsp_kv_d = (op_q == PQ_POP) ? hd_q : '0;
          state_d  = ST_RESP;
        end else if (wcnt_q == TW'(TMO-1)) begin
          err_d    = 1'b1;
          rsp_kv_d = '0;
          state_d  = ST_RESP;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end

      ST_RESP: begin
        rsp_valid = NREQ'(1) << id_q;
        rsp_err   = err_q;
        if (!err_q) begin
          if (op_q == PQ_PUSH && count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
          if (op_q == PQ_POP && count_q != '0)          count_d = count_q - CW'(1);
        end
        // Advance past the served client even on errors so nobody starves.
        ptr_d   = (id_q == IW'(NREQ-1)) ? '0 : id_q + IW'(1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_kv = rsp_kv_q;
  assign count  = count_q;
endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched with a small behavioural quickq (min-key head, programmable busy time).
module tb_pq_sched;
  import pq_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*KV_W-1:0] req_kv;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [KV_W-1:0]      rsp_kv;
  logic                 rsp_err;
  logic                 pq_enq;
  logic                 pq_deq;
  logic [KV_W-1:0]      pq_kvi;
  logic [KV_W-1:0]      pq_kvo;
  logic                 pq_full;
  logic                 pq_empty;
  logic                 pq_busy;
  logic [4:0]           count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pq_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_kv    (req_kv),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_kv    (rsp_kv),
    .rsp_err   (rsp_err),
    .pq_enq    (pq_enq),
    .pq_deq    (pq_deq),
    .pq_kvi    (pq_kvi),
    .pq_kvo    (pq_kvo),
    .pq_full   (pq_full),
    .pq_empty  (pq_empty),
    .pq_busy   (pq_busy)
    ,.count    (count)
  );

  // Behavioural quickq: unsorted store, head is the minimum key.
  kv_t mem [DEPTH];
  int  n_q;
  int  last_i;
  int  hidx;
  int  busy_cnt;
  int  busy_len;

  assign last_i   = n_q - 1;
  assign pq_full  = (n_q >= DEPTH);
  assign pq_empty = (n_q == 0);
  assign pq_busy  = (busy_cnt != 0);
  assign pq_kvo   = (n_q == 0) ? '0 : mem[hidx[3:0]];

  always_comb begin
    hidx = 0;
    for (int i = 1; i < DEPTH; i++)
      if (i < n_q && mem[i].key < mem[hidx[3:0]].key) hidx = i;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= 0;
      busy_cnt <= 0;
    end else begin
      if (pq_enq && n_q < DEPTH) begin
        mem[n_q[3:0]] <= pq_kvi;
        n_q           <= n_q + 1;
      end else if (pq_deq && n_q > 0) begin
        mem[hidx[3:0]] <= mem[last_i[3:0]];
        n_q            <= n_q - 1;
      end
      if (pq_enq || pq_deq)  busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request from client c; latency counted from the accept cycle (0) to rsp_valid.
  task automatic run_op(input int c, input logic op, input logic [KV_W-1:0] kv,
                        input logic exp_err, input logic [KV_W-1:0] exp_kv,
                        input int exp_lat, input int exp_strb, input string tag);
    int t;
    int lat;
    int strb;
    logic [KV_W-1:0] kvi_seen;
    @(negedge clk);
    req_valid[c] = 1'b1;
    req_op[c]    = op;
    req_kv[c*KV_W +: KV_W] = kv;
    #1;
    t = 0;
    while (req_ready[c] !== 1'b1 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check_eq({tag, ".ready"}, 32'(req_ready), 1 << c);
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
    lat = 0; strb = 0; kvi_seen = '0;
    do begin
      @(negedge clk);
      lat++;
      if (pq_enq || pq_deq) strb++;
      if (pq_enq) kvi_seen = pq_kvi;
    end while (rsp_valid == '0 && lat < 200);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 1 << c);
    check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check_eq({tag, ".rsp_kv"}, 32'(rsp_kv), 32'(exp_kv));
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".strobes"}, strb, exp_strb);
    if (op == PQ_PUSH && exp_strb > 0) check_eq({tag, ".pq_kvi"}, 32'(kvi_seen), 32'(kv));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".req_ready"}, 32'(req_ready), 0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, ".rsp_err"}, 32'(rsp_err), 0);
    check_eq({tag, ".pq_enq"}, 32'(pq_enq), 0);
    check_eq({tag, ".pq_deq"}, 32'(pq_deq), 0);
    check_eq({tag, ".pq_kvi"}, 32'(pq_kvi), 0);
    check_eq({tag, ".rsp_kv"}, 32'(rsp_kv), 0);
    check_eq({tag, ".count"}, 32'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_op    = '0;
    req_kv    = '0;
    busy_len  = 2;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    #1;
    check_eq("post_reset.req_ready", 32'(req_ready), 0);

    // Push {5,0xA} then pop it back, client 0.
    run_op(0, PQ_PUSH, 24'h05000A, 1'b0, 24'h0, 5, 1, "push0");
    @(negedge clk); check_eq("push0.count", 32'(count), 1);
    run_op(0, PQ_POP, 24'h0, 1'b0, 24'h05000A, 5, 1, "pop0");
    @(negedge clk); check_eq("pop0.count", 32'(count), 0);

    // Pops on an empty queue: error after 2 cycles, no strobe; client 3 also brings ptr back to 0.
    run_op(2, PQ_POP, 24'h0, 1'b1, 24'h0, 2, 0, "pop_empty2");
    @(negedge clk); check_eq("pop_empty2.count", 32'(count), 0);
    run_op(3, PQ_POP, 24'h0, 1'b1, 24'h0, 2, 0, "pop_empty3");

    // All four clients push from the same cycle: expect grants 0,1,2,3.
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_kv[i*KV_W +: KV_W] = {8'h10 + 8'(i), 16'h0100 + 16'(i)};
    req_op    = '0;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < NREQ; k++) begin
      t = 0;
      while (req_ready == '0 && t < 50) begin
        @(negedge clk); #1; t++;
      end
      check_eq("rr.grant", 32'(req_ready), 1 << k);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      @(negedge clk); #1;
      check_eq("rr.pulse", 32'(req_ready), 0);
      t = 0;
      while (rsp_valid == '0 && t < 50) begin
        @(negedge clk); t++;
      end
      check_eq("rr.rsp_valid", 32'(rsp_valid), 1 << k);
      check_eq("rr.rsp_err", 32'(rsp_err), 0);
    end
    @(negedge clk); check_eq("rr.count", 32'(count), 4);
    run_op(0, PQ_PUSH, 24'h300000, 1'b0, 24'h0, 5, 1, "wrap");

    // Fill to DEPTH, then one push too many.
    for (int i = 0; i < 11; i++)
      run_op(i % NREQ, PQ_PUSH, {8'h20 + 8'(i), 16'h0}, 1'b0, 24'h0, 5, 1, "fill");
    @(negedge clk); check_eq("fill.count", 32'(count), 16);
    run_op(0, PQ_PUSH, 24'h010000, 1'b1, 24'h0, 2, 0, "full");
    @(negedge clk); check_eq("full.count", 32'(count), 16);

    // quickq stays busy for 70 cycles: watchdog fires after 64 WAIT cycles.
    busy_len = 70;
    run_op(1, PQ_POP, 24'h0, 1'b1, 24'h0, 66, 1, "tmo");
    @(negedge clk); check_eq("tmo.count", 32'(count), 16);
    repeat (10) @(negedge clk);

    // Reset in the middle of WAIT, then check the pointer restarts at 0.
    busy_len = 10;
    @(negedge clk);
    req_op[0] = PQ_PUSH;
    req_kv[0 +: KV_W] = 24'h7700AA;
    req_valid[0] = 1'b1;
    #1;
    t = 0;
    while (req_ready[0] !== 1'b1 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check_eq("rst.ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("rst.issue_enq", 32'(pq_enq), 1);
    @(negedge clk);
    req_op[3]    = PQ_PUSH;
    req_valid[3] = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_wait");
    @(negedge clk);
    req_op[1]    = PQ_PUSH;
    req_valid[1] = 1'b1;
    rst_n        = 1'b1;
    #1;
    check_eq("rst.ptr_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
